// File: rtl/input_conditioner_pkg.sv
// Shared constants for the input conditioner: debounce lengths and channel counts.
package input_conditioner_pkg;

    // Hardware debounce length (10 ms at 100 MHz) and a short simulation stand-in.
    localparam int DEBOUNCE_SYNTH = 1000000;
    localparam int DEBOUNCE_SIM   = 4;

`ifdef SYNTHESIS
    localparam int DEBOUNCE_DEFAULT = DEBOUNCE_SYNTH;
`else
    localparam int DEBOUNCE_DEFAULT = DEBOUNCE_SIM;
`endif

    // Basys3 channel counts: five push buttons, sixteen slide switches.
    localparam int N_BTN = 5;
    localparam int N_SW  = 16;

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_debounce_cell.sv
// Single-channel debouncer: two-flop synchroniser, stability counter,
// debounced level and registered press/release pulses.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press_pulse;
    logic             r_release_pulse;

    logic w_differs;
    logic w_accept;

    // A new level is accepted once the synchronised input has differed for DEBOUNCE_CYCLES samples.
    assign w_differs = (r_s2 != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_MAX);

    // Rising acceptance, exposed one cycle early so the top can set sticky flags on the pulse edge.
    assign o_rise = w_accept && r_s2;

    // Synchronise, count stable samples, update the level and generate edge pulses.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep r_s1 -> r_s2 a true two-stage pipeline regardless of statement order.
        if (reset) begin
            r_s1            <= 1'b0;
            r_s2            <= 1'b0;
            r_cnt           <= '0;
            r_level         <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_s1            <= i_raw;
            r_s2            <= r_s1;
            r_press_pulse   <= w_accept && r_s2;
            r_release_pulse <= w_accept && !r_s2;
            if (!w_differs) begin
                // Any bounce back to the current level discards the partial count.
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level         = r_level;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;

endmodule : debounce_cell

// File: rtl/input_conditioner.sv
// Input conditioner: per-channel debouncing of raw pads plus sticky press
// flags that software clears through a masked clear strobe.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_IN            = N_BTN,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] raw_in,
    input  logic            clr,
    input  logic [N_IN-1:0] clr_mask,
    output logic [N_IN-1:0] level,
    output logic [N_IN-1:0] press_pulse,
    output logic [N_IN-1:0] release_pulse,
    output logic [N_IN-1:0] press_sticky
);

    logic [N_IN-1:0] w_rise;
    logic [N_IN-1:0] w_clear;
    logic [N_IN-1:0] r_press_sticky;

    // One independent debouncer per channel.
    for (genvar g = 0; g < N_IN; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk            (clk),
            .reset          (reset),
            .i_raw          (raw_in[g]),
            .o_level        (level[g]),
            .o_press_pulse  (press_pulse[g]),
            .o_release_pulse(release_pulse[g]),
            .o_rise         (w_rise[g])
        );
    end

    assign w_clear = {N_IN{clr}} & clr_mask;

    // Sticky press flags: a set on the same edge as a clear wins so no press is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_press_sticky <= '0;
        end else begin
            r_press_sticky <= (r_press_sticky & ~w_clear) | w_rise;
        end
    end

    assign press_sticky = r_press_sticky;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4, N_IN = 5.
module tb_input_conditioner;

    localparam int N_IN = 5;
    localparam int DEB  = 4;

    typedef struct packed {
        logic [N_IN-1:0] lvl;
        logic [N_IN-1:0] pp;
        logic [N_IN-1:0] rp;
        logic [N_IN-1:0] st;
    } obs_t;

    logic            clk;
    logic            reset;
    logic [N_IN-1:0] raw_in;
    logic            clr;
    logic [N_IN-1:0] clr_mask;
    logic [N_IN-1:0] level;
    logic [N_IN-1:0] press_pulse;
    logic [N_IN-1:0] release_pulse;
    logic [N_IN-1:0] press_sticky;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    input_conditioner #(
        .N_IN           (N_IN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_in       (raw_in),
        .clr          (clr),
        .clr_mask     (clr_mask),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_sticky (press_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [N_IN-1:0] l, input logic [N_IN-1:0] p,
                                input logic [N_IN-1:0] r, input logic [N_IN-1:0] s);
        obs_t o;
        o.lvl = l;
        o.pp  = p;
        o.rp  = r;
        o.st  = s;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(level, press_pulse, release_pulse, press_sticky);
    endfunction

    // Advance one rising edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        raw_in = '0;
        for (int i = 0; i < 7; i++) begin
            reset = (i < 3);
            exp_q.push_back(mk('0, '0, '0, '0));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_press();
        obs_t got, want;
        raw_in[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            exp_q.push_back(mk((e >= 6) ? 5'h01 : 5'h00, (e == 6) ? 5'h01 : 5'h00,
                               5'h00, (e >= 6) ? 5'h01 : 5'h00));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL press edge %0d: got %h expected %h", e, got, want);
            end
        end
    endtask

    task automatic test_bounce();
        obs_t got, want;
        // Two bursts of 3 high / 2 low cycles: never long enough to be accepted.
        for (int i = 0; i < 10; i++) begin
            raw_in[1] = ((i % 5) < 3);
            exp_q.push_back(mk(5'h01, 5'h00, 5'h00, 5'h01));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bounce cycle %0d: got %h expected %h", i, got, want);
            end
        end
        raw_in[1] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            exp_q.push_back(mk((e >= 6) ? 5'h03 : 5'h01, (e == 6) ? 5'h02 : 5'h00,
                               5'h00, (e >= 6) ? 5'h03 : 5'h01));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bounce_settle edge %0d: got %h expected %h", e, got, want);
            end
        end
    endtask

    task automatic test_clear();
        obs_t got, want;
        logic             clr_tab  [3] = '{1'b1, 1'b1, 1'b0};
        logic [N_IN-1:0]  mask_tab [3] = '{5'h01, 5'h00, 5'h1F};
        for (int i = 0; i < 3; i++) begin
            clr      = clr_tab[i];
            clr_mask = mask_tab[i];
            exp_q.push_back(mk(5'h03, 5'h00, 5'h00, 5'h02));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clear step %0d: got %h expected %h", i, got, want);
            end
        end
        clr      = 1'b0;
        clr_mask = '0;
    endtask

    task automatic test_set_wins();
        obs_t got, want;
        raw_in[2] = 1'b1;
        clr_mask  = 5'h04;
        for (int e = 1; e <= 8; e++) begin
            // Clear sampled on the setting edge (set wins), then on the following edge (clears).
            clr = (e == 6) || (e == 7);
            exp_q.push_back(mk((e >= 6) ? 5'h07 : 5'h03, (e == 6) ? 5'h04 : 5'h00,
                               5'h00, (e == 6) ? 5'h06 : 5'h02));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL set_wins edge %0d: got %h expected %h", e, got, want);
            end
        end
        clr      = 1'b0;
        clr_mask = '0;
    endtask

    task automatic test_release();
        obs_t got, want;
        raw_in[0] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            exp_q.push_back(mk((e >= 6) ? 5'h06 : 5'h07, 5'h00,
                               (e == 6) ? 5'h01 : 5'h00, 5'h02));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL release edge %0d: got %h expected %h", e, got, want);
            end
        end
    endtask

    task automatic test_reset_restart();
        obs_t got, want;
        raw_in = 5'h08;
        // Reset 2 edges, run 3, reset again on the 2 edges before the rise, then run 8.
        for (int i = 0; i < 15; i++) begin
            reset = (i < 2) || (i == 5) || (i == 6);
            exp_q.push_back(mk((i >= 12) ? 5'h08 : 5'h00, (i == 12) ? 5'h08 : 5'h00,
                               5'h00, (i >= 12) ? 5'h08 : 5'h00));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_restart cycle %0d: got %h expected %h", i, got, want);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_multi();
        obs_t got, want;
        raw_in = 5'h17;
        for (int e = 1; e <= 8; e++) begin
            exp_q.push_back(mk((e >= 6) ? 5'h17 : 5'h08, (e == 6) ? 5'h17 : 5'h00,
                               (e == 6) ? 5'h08 : 5'h00, (e >= 6) ? 5'h1F : 5'h08));
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL multi edge %0d: got %h expected %h", e, got, want);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        raw_in   = '0;
        clr      = 1'b0;
        clr_mask = '0;
        test_reset();
        test_press();
        test_bounce();
        test_clear();
        test_set_wins();
        test_release();
        test_reset_restart();
        test_multi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_input_conditioner
